// File: rtl/if_pkg.sv
// Shared defaults and the prefetch-queue entry type for the instruction-fetch stage.
// No logic; widths here are the defaults the stage and its queue are built with.
package if_pkg;

    localparam int IF_AW         = 32;
    localparam int IF_DW         = 32;
    localparam int IF_DEPTH      = 4;
    localparam int IF_INST_BYTES = 4;

    localparam logic [IF_AW-1:0] IF_RESET_PC = '0;

    typedef struct packed {
        logic [IF_AW-1:0] addr;
        logic [IF_DW-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetched {addr,data}; push visible at the head next cycle.
// Flush wins over push/pop in the same cycle; a push into a full queue is dropped unless it pops too.
module if_prefetch_fifo
    import if_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = IF_DEPTH,
    parameter int  CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        push_dat,
    output entry_t        head_dat,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with prefetch queue: pipelined req/gnt fetches, in-order delivery to ID.
// Response -> inst_valid one cycle later; freeze holds the head, credit stops fetching when full.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int            AW         = IF_AW,
    parameter int            DW         = IF_DW,
    parameter int            DEPTH      = IF_DEPTH,
    parameter int            INST_BYTES = IF_INST_BYTES,
    parameter logic [AW-1:0] RESET_PC   = AW'(IF_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_addr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          inst_valid,
    output logic [DW-1:0] instruction,
    output logic [AW-1:0] pc
);

    localparam int            CW         = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] STEP       = AW'(INST_BYTES);
    localparam logic [AW-1:0] ALIGN_MASK = ~(STEP - 1'b1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] count;
    logic [CW+1:0] credit_used;
    logic          accept, drop, resp_ok, push, pop;
    entry_t        push_entry, head;

    // Stale fetches still awaiting their response hold credit until they are dropped.
    assign credit_used = (CW+2)'(count) + (CW+2)'(out_q) + (CW+2)'(disc_q);
    assign mem_req     = !rst && !branch_taken && (credit_used < (CW+2)'(DEPTH));
    assign mem_addr    = fetch_pc_q;
    assign accept      = mem_req && mem_gnt;

    assign drop        = mem_rvalid && (disc_q != '0);
    assign resp_ok     = mem_rvalid && (disc_q == '0) && (out_q != '0);
    assign push        = resp_ok && !branch_taken;

    assign inst_valid  = (count != '0);
    assign pop         = inst_valid && !freeze && !branch_taken;
    assign instruction = inst_valid ? head.data : '0;
    assign pc          = inst_valid ? head.addr : '0;

    assign push_entry.addr = resp_pc_q;
    assign push_entry.data = mem_rdata;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        disc_d     = disc_q;
        if (branch_taken) begin
            fetch_pc_d = branch_addr & ALIGN_MASK;
            resp_pc_d  = branch_addr & ALIGN_MASK;
            out_d      = '0;
            // Everything in flight becomes stale, minus the one response retiring now.
            disc_d     = disc_q + out_q - CW'(drop || resp_ok);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + STEP;
            if (push)   resp_pc_d  = resp_pc_q + STEP;
            out_d  = out_q + CW'(accept) - CW'(push);
            disc_d = disc_q - CW'(drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_rvalid && (out_q == '0) && (disc_q == '0)))
                else $error("if_prefetch_stage: rvalid with no fetch in flight");
        end
    end

    if_prefetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH),
        .CW      (CW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (branch_taken),
        .push_dat (push_entry),
        .head_dat (head),
        .count    (count)
    );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed phases plus a randomized run against a queue-level model.
module tb_if_prefetch_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, mem_gnt, mem_rvalid;
    logic [31:0] branch_addr, mem_rdata;
    logic        mem_req, inst_valid;
    logic [31:0] mem_addr, instruction, pc;

    always #5 clk = ~clk;

    if_prefetch_stage #(
        .AW(32), .DW(32), .DEPTH(DEPTH), .INST_BYTES(4), .RESET_PC(32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .inst_valid   (inst_valid),
        .instruction  (instruction),
        .pc           (pc)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: fetches accepted but not yet answered (stale ones were overtaken by a branch),
    // plus the number and head address of instructions waiting for ID.
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    bit          pend_stale[$];
    int          qn;
    logic [31:0] exp_fetch, exp_head;

    int gnt_pct = 100;
    int lat     = 1;
    bit frz     = 1'b0;
    int acc_dut = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_addr.delete();
        pend_due.delete();
        pend_stale.delete();
        qn        = 0;
        exp_fetch = 32'h0;
        exp_head  = 32'h0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        freeze       = 1'b0;
        @(posedge clk); #1;
        cyc++;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic cycle(input bit br, input logic [31:0] baddr);
        bit exp_req, acc, popd;
        int tot;
        freeze       = frz;
        branch_taken = br;
        branch_addr  = baddr;
        mem_gnt      = ($urandom_range(99) < gnt_pct);
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(pend_addr[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        #2;
        tot     = pend_addr.size() + qn;
        exp_req = !br && (tot < DEPTH);
        chk("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
        if (exp_req) chk("mem_addr", mem_addr, exp_fetch);
        chk("inst_valid", {31'h0, inst_valid}, (qn > 0) ? 32'h1 : 32'h0);
        chk("pc", pc, (qn > 0) ? exp_head : 32'h0);
        chk("instruction", instruction, (qn > 0) ? mem_word(exp_head) : 32'h0);
        if (mem_req && mem_gnt) acc_dut++;

        acc  = exp_req && mem_gnt;
        popd = (qn > 0) && !frz && !br;
        if (mem_rvalid) begin
            if (!pend_stale[0] && !br) qn++;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            void'(pend_stale.pop_front());
        end
        if (popd) begin
            qn--;
            exp_head += 32'd4;
        end
        if (acc) begin
            pend_addr.push_back(exp_fetch);
            pend_due.push_back(cyc + lat);
            pend_stale.push_back(1'b0);
            exp_fetch += 32'd4;
        end
        if (br) begin
            qn = 0;
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
            exp_fetch = baddr & ~32'h3;
            exp_head  = exp_fetch;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        model_reset();
        do_reset();

        // Streaming fetch: first instruction after a two-cycle fill.
        gnt_pct = 100; lat = 1; frz = 1'b0;
        cycle(0, 0);
        cycle(0, 0);
        chk("fill_valid", {31'h0, inst_valid}, 32'h1);
        chk("fill_pc", pc, 32'h0);
        repeat (10) cycle(0, 0);

        // Freeze from reset: credit admits exactly DEPTH fetches.
        do_reset();
        frz = 1'b1; acc_dut = 0;
        repeat (10) cycle(0, 0);
        chk("freeze_accepts", acc_dut, DEPTH);
        chk("freeze_head_pc", pc, 32'h0);
        frz = 1'b0;
        repeat (10) cycle(0, 0);

        // Branch with three fetches outstanding: their responses are dropped.
        do_reset();
        lat = 6;
        repeat (3) cycle(0, 0);
        cycle(1, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (inst_valid) seen = 1'b1;
            else cycle(0, 0);
        end
        chk("branch_valid_seen", {31'h0, seen}, 32'h1);
        chk("branch_first_pc", pc, 32'h100);

        // Misaligned target, then a branch colliding with rvalid and pop.
        lat = 1;
        cycle(1, 32'h103);
        chk("align_fetch_addr", mem_addr, 32'h100);
        repeat (6) cycle(0, 0);
        cycle(1, 32'h40);
        chk("br_rvalid_pop_empty", {31'h0, inst_valid}, 32'h0);
        repeat (6) cycle(0, 0);

        // Grant withheld, then fetch across the top of the address space.
        gnt_pct = 0;
        cycle(1, 32'hFFFF_FFF4);
        repeat (5) cycle(0, 0);
        gnt_pct = 100;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid && pc == 32'h0) seen = 1'b1;
            cycle(0, 0);
        end
        chk("wrap_seen", {31'h0, seen}, 32'h1);

        // Reset with instructions queued and fetches in flight.
        do_reset();
        frz = 1'b1; lat = 1;
        repeat (2) cycle(0, 0);
        lat = 30;
        repeat (3) cycle(0, 0);
        do_reset();
        frz = 1'b0; lat = 1;
        repeat (6) cycle(0, 0);

        // Randomized traffic.
        gnt_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            frz = ($urandom_range(9) < 3);
            lat = $urandom_range(1, 4);
            if ($urandom_range(299) == 0) do_reset();
            else cycle($urandom_range(24) == 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
